fetch_inst_queue: RTL and testbench
===================================

// Module: fetch_inst_queue
// PURPOSE
//  Instruction queue between fetch stage 2 and decode: the receiving end of the FS2 packet interface.
//  Accepts up to 4 instruction packets per cycle, with per-slot valid bits, and compacts them in program order into a circular buffer.
//  Presents the oldest 4 entries to decode.
//  Back-pressures fetch through full_o and discards all contents on flush/recovery.
// PARAMETERS
//  PKT_W    133  packet width {instruction, pc, targetAddr, ctiqTag, prediction}
//  DEPTH    16   entries; power of two, >= 8
//  DEPTH_LOG 4   log2(DEPTH)
// PORTS
//  clk             in   1        clock; all state updates on rising edge
//  reset           in   1        asynchronous, active-high reset
//  flush_i         in   1        synchronous flush (recovery/exception)
//  wrEn_i          in   1        bundle present this cycle (FS2 ready & ~stall)
//  wrValid_i       in   4        slot valids; bit0 = inst0 = oldest
//  wrPkt0_i..3_i   in   PKT_W    slot packets 0..3
//  full_o          out  1        cannot guarantee space for a 4-wide bundle
//  rdReady_i       in   1        decode accepts the presented entries
//  rdValid_o       out  4        bit k = entry head+k is valid
//  rdPkt0_o..3_o   out  PKT_W    entries head+0..head+3
//  count_o         out  DEPTH_LOG+1  occupancy
// BEHAVIOUR
//  State: head and tail pointers (DEPTH_LOG bits, wrap modulo DEPTH); count (DEPTH_LOG+1 bits); entry array.
//  Reset (async): head=tail=count=0. Entry contents need not be reset.
//   Resulting outputs: rdValid_o=0, full_o=0, count_o=0.
//  full_o = (count > DEPTH-4), combinational from registered count.
//  Write: accepted iff wrEn_i & ~full_o & ~flush_i.
//   nWr = popcount(wrValid_i). Valid slots are written in ascending slot order to tail, tail+1, ... (compaction).
//   Invalid slots are skipped, so pattern 4'b0101 writes slot0 then slot2.
//   wrEn_i while full_o: bundle dropped, no state change. Fetch must hold the bundle itself.
//  Read: rdValid_o[k] = (count > k). rdPktk_o = entry[(head+k) mod DEPTH], combinational.
//   If rdReady_i & ~flush_i: nRd = popcount(rdValid_o), i.e. min(count,4); head += nRd.
//  Count update: count_next = count + nWr - nRd. Write and read in the same cycle are both legal.
//   full_o and rdValid_o use the pre-update count, so there is no same-cycle bypass.
//  Latency: a packet written in cycle N appears on rdPkt*_o in cycle N+1 at the earliest.
//  Flush: flush_i=1 sets head=tail=count=0 at the next edge.
//   Flush has priority over a simultaneous write and read; both are ignored.
//  Wrap-around: all pointer arithmetic is modulo DEPTH. Compacted writes and 4-wide reads may straddle entry DEPTH-1 -> 0.
//  count never exceeds DEPTH. Write acceptance guarantees this because full_o asserts at count >= DEPTH-3.
// TESTING
//  Reset mid-operation: count=7, assert reset -> same cycle rdValid_o=0000, count_o=0, full_o=0.
//  Fill: 4 bundles of wrValid=1111, rdReady=0 -> count 4,8,12 (full_o=1 at 13+? no: at 13).
//   After the 3rd bundle: count=12, full_o=0. 4th accepted -> count=16, full_o=1.
//   5th bundle -> dropped, count stays 16.
//  Compaction: wrValid=1100 (pkts A,B), then 1000 (C), then 0101 (D,E).
//   -> read order A,B,C,D,E; rdValid_o=1111 after the third write.
//  Wrap: cycle the queue so head=14, write 1111 -> entries 14,15,0,1.
//   rdPkt0..3 show them in order; after rdReady, head=2.
//  Simultaneous: count=5, rdReady=1, write 1110 -> count_next=5-4+3=4, head+=4, tail+=3.
//  Flush priority: count=9, flush_i=1 with wrEn_i=1, wrValid=1111, rdReady_i=1 -> next cycle count=0, rdValid_o=0000.
//   A write in the following cycle lands at entry 0.

Source files
------------

// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch stage 2 and decode: compacts up to four valid
// packets per cycle into a circular buffer and presents the oldest four to decode.
module fetch_inst_queue #(
  parameter int PKT_W     = 133,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 wrEn_i,
  input  logic [3:0]           wrValid_i,
  input  logic [PKT_W-1:0]     wrPkt0_i,
  input  logic [PKT_W-1:0]     wrPkt1_i,
  input  logic [PKT_W-1:0]     wrPkt2_i,
  input  logic [PKT_W-1:0]     wrPkt3_i,
  output logic                 full_o,
  input  logic                 rdReady_i,
  output logic [3:0]           rdValid_o,
  output logic [PKT_W-1:0]     rdPkt0_o,
  output logic [PKT_W-1:0]     rdPkt1_o,
  output logic [PKT_W-1:0]     rdPkt2_o,
  output logic [PKT_W-1:0]     rdPkt3_o,
  output logic [DEPTH_LOG:0]   count_o
);

  localparam int CW = DEPTH_LOG + 1;
  localparam logic [CW-1:0] FULL_LIM = CW'(DEPTH - 4);
  localparam logic [CW-1:0] CNT_FOUR = CW'(4);

  logic [DEPTH_LOG-1:0] headQ, headD;
  logic [DEPTH_LOG-1:0] tailQ, tailD;
  logic [CW-1:0]        countQ, countD;
  logic [PKT_W-1:0]     mem [DEPTH];

  logic [PKT_W-1:0]     wrPkt [4];
  logic [PKT_W-1:0]     rdPkt [4];
  logic [DEPTH_LOG-1:0] slotAddr [4];
  logic [2:0]           nWr;
  logic [2:0]           wrN;
  logic [2:0]           nRd;
  logic                 wrAccept;
  logic                 rdFire;

  assign wrPkt[0] = wrPkt0_i;
  assign wrPkt[1] = wrPkt1_i;
  assign wrPkt[2] = wrPkt2_i;
  assign wrPkt[3] = wrPkt3_i;

  assign full_o   = (countQ > FULL_LIM);
  assign count_o  = countQ;
  assign wrAccept = wrEn_i & ~full_o & ~flush_i;
  assign rdFire   = rdReady_i & ~flush_i;

  // Each valid slot lands at tail plus the number of valid slots below it,
  // which squeezes out the holes left by invalid slots.
  always_comb begin
    logic [2:0] run;
    run = '0;
    for (int s = 0; s < 4; s++) begin
      slotAddr[s] = tailQ + DEPTH_LOG'(run);
      run = run + 3'(wrValid_i[s]);
    end
    nWr = run;
  end

  always_comb begin
    wrN    = wrAccept ? nWr : 3'd0;
    nRd    = 3'd0;
    if (rdFire) begin
      nRd = (countQ >= CNT_FOUR) ? 3'd4 : countQ[2:0];
    end
    headD  = headQ + DEPTH_LOG'(nRd);
    tailD  = tailQ + DEPTH_LOG'(wrN);
    countD = countQ + CW'(wrN) - CW'(nRd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else if (flush_i) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      for (int s = 0; s < 4; s++) begin
        if (wrValid_i[s]) begin
          mem[slotAddr[s]] <= wrPkt[s];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdPkt[k]     = mem[headQ + DEPTH_LOG'(k)];
      rdValid_o[k] = (countQ > CW'(k));
    end
  end

  assign rdPkt0_o = rdPkt[0];
  assign rdPkt1_o = rdPkt[1];
  assign rdPkt2_o = rdPkt[2];
  assign rdPkt3_o = rdPkt[3];

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized scoreboard bench for fetch_inst_queue against a queue-based
// model of the instruction buffer.
module tb_fetch_inst_queue;

  localparam int PKT_W  = 133;
  localparam int DEPTH  = 16;
  localparam int CYCLES = 3000;

  typedef struct packed {
    logic [4:0]             cnt;
    logic                   full;
    logic [3:0]             vld;
    logic [3:0][PKT_W-1:0]  pkts;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             flush_i;
  logic             wrEn_i;
  logic [3:0]       wrValid_i;
  logic [PKT_W-1:0] wrPkt0_i, wrPkt1_i, wrPkt2_i, wrPkt3_i;
  logic             full_o;
  logic             rdReady_i;
  logic [3:0]       rdValid_o;
  logic [PKT_W-1:0] rdPkt0_o, rdPkt1_o, rdPkt2_o, rdPkt3_o;
  logic [4:0]       count_o;

  logic [PKT_W-1:0] model [$];
  exp_t             expQ [$];
  int               checks;
  int               failures;
  bit               didReset7;

  fetch_inst_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH), .DEPTH_LOG(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush_i),
    .wrEn_i    (wrEn_i),
    .wrValid_i (wrValid_i),
    .wrPkt0_i  (wrPkt0_i),
    .wrPkt1_i  (wrPkt1_i),
    .wrPkt2_i  (wrPkt2_i),
    .wrPkt3_i  (wrPkt3_i),
    .full_o    (full_o),
    .rdReady_i (rdReady_i),
    .rdValid_o (rdValid_o),
    .rdPkt0_o  (rdPkt0_o),
    .rdPkt1_o  (rdPkt1_o),
    .rdPkt2_o  (rdPkt2_o),
    .rdPkt3_o  (rdPkt3_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] randPkt();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[PKT_W-1:0];
  endfunction

  // Expected outputs follow only from what the queue holds right now.
  function automatic exp_t expectNow();
    exp_t e;
    int   n;
    n      = model.size();
    e      = '0;
    e.cnt  = 5'(n);
    e.full = (n > DEPTH - 4);
    for (int k = 0; k < 4; k++) begin
      e.vld[k] = (n > k);
      if (n > k) e.pkts[k] = model[k];
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [PKT_W-1:0] act,
                             input logic [PKT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one cycle of inputs, then advances the model as the queue should.
  task automatic applyStimulus(input int wrPct, input int rdPct);
    logic [PKT_W-1:0] pk [4];
    int               n;
    int               nRd;
    @(negedge clk);
    if (reset) reset = 1'b0;
    if ((!didReset7 && model.size() == 7) || ($urandom_range(0, 199) == 0)) begin
      if (model.size() == 7) didReset7 = 1'b1;
      reset = 1'b1;
      model.delete();
    end
    expQ.push_back(expectNow());
    for (int s = 0; s < 4; s++) pk[s] = randPkt();
    flush_i   = ($urandom_range(0, 99) < 3);
    wrEn_i    = ($urandom_range(0, 99) < wrPct);
    wrValid_i = 4'($urandom_range(0, 15));
    rdReady_i = ($urandom_range(0, 99) < rdPct);
    wrPkt0_i  = pk[0];
    wrPkt1_i  = pk[1];
    wrPkt2_i  = pk[2];
    wrPkt3_i  = pk[3];
    @(posedge clk);
    if (reset || flush_i) begin
      model.delete();
    end else begin
      n   = model.size();
      nRd = rdReady_i ? ((n < 4) ? n : 4) : 0;
      for (int i = 0; i < nRd; i++) void'(model.pop_front());
      if (wrEn_i && n <= DEPTH - 4) begin
        for (int s = 0; s < 4; s++) if (wrValid_i[s]) model.push_back(pk[s]);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [PKT_W-1:0] act [4];
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act[0] = rdPkt0_o;
        act[1] = rdPkt1_o;
        act[2] = rdPkt2_o;
        act[3] = rdPkt3_o;
        checkOutput("count", PKT_W'(count_o), PKT_W'(e.cnt));
        checkOutput("full", PKT_W'(full_o), PKT_W'(e.full));
        checkOutput("rdValid", PKT_W'(rdValid_o), PKT_W'(e.vld));
        for (int k = 0; k < 4; k++) begin
          if (e.vld[k]) checkOutput($sformatf("rdPkt%0d", k), act[k], e.pkts[k]);
        end
      end
    end
  end

  initial begin : stimulus
    int drain;
    checks    = 0;
    failures  = 0;
    didReset7 = 1'b0;
    reset     = 1'b1;
    flush_i   = 1'b0;
    wrEn_i    = 1'b0;
    wrValid_i = 4'b0;
    rdReady_i = 1'b0;
    wrPkt0_i  = '0;
    wrPkt1_i  = '0;
    wrPkt2_i  = '0;
    wrPkt3_i  = '0;
    for (int c = 0; c < CYCLES; c++) begin
      case ((c / 250) % 3)
        0:       applyStimulus(90, 15);
        1:       applyStimulus(60, 60);
        default: applyStimulus(30, 90);
      endcase
    end
    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #5;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
